// File: rtl/ins_queue_pkg.sv
// Shared types and constants for the fetch-to-decode instruction queue.
// Entry layout is {inst, pc, pred_jump}.
package ins_queue_pkg;

    localparam int unsigned INS_QUEUE_DEPTH = 16;
    localparam int unsigned INS_QUEUE_PTR_W = 4;
    localparam int unsigned INST_W          = 32;
    localparam int unsigned ADDR_W          = 32;

    typedef logic [INST_W-1:0] ins_type_t;
    typedef logic [ADDR_W-1:0] addr_type_t;

    localparam logic      TRUE      = 1'b1;
    localparam logic      FALSE     = 1'b0;
    localparam ins_type_t ZERO_WORD = '0;
    localparam addr_type_t ZERO_ADDR = '0;

    typedef struct packed {
        ins_type_t  inst;
        addr_type_t pc;
        logic       pred_jump;
    } iq_entry_t;

endpackage

// File: rtl/ins_queue.sv
// Circular instruction buffer between fetch and decode, with a show-ahead head.
// Optional INS_QUEUE_BYPASS_EN forwards the fetch input straight out when empty.
module ins_queue
    import ins_queue_pkg::*;
#(
    parameter int unsigned DEPTH = INS_QUEUE_DEPTH,
    parameter int unsigned PTR_W = INS_QUEUE_PTR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rdy,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [INST_W-1:0] in_inst,
    input  logic [ADDR_W-1:0] in_pc,
    input  logic              in_pred_jump,
    output logic              in_ready,
    output logic              out_valid,
    output logic [INST_W-1:0] out_inst,
    output logic [ADDR_W-1:0] out_pc,
    output logic              out_pred_jump,
    input  logic              deq_ready
);

    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    iq_entry_t mem_q [DEPTH];
    iq_entry_t head_entry;

    logic empty;
    logic full;
    logic enq;
    logic deq;

    // Occupancy flags and the enqueue/dequeue qualifiers.
    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == CNT_W'(DEPTH));
        in_ready = ~full;
        deq      = rdy & ~empty & deq_ready & ~flush;
`ifdef INS_QUEUE_BYPASS_EN
        // A bypassed instruction consumed in the same cycle never touches storage.
        enq      = rdy & in_valid & ~full & ~flush & ~(empty & deq_ready);
`else
        enq      = rdy & in_valid & ~full & ~flush;
`endif
    end

    // Show-ahead head; reads zero while empty so stale storage never leaks out.
    always_comb begin
        head_entry    = mem_q[head_q];
        out_valid     = ~empty;
        out_inst      = ZERO_WORD;
        out_pc        = ZERO_ADDR;
        out_pred_jump = FALSE;
        if (!empty) begin
            out_inst      = head_entry.inst;
            out_pc        = head_entry.pc;
            out_pred_jump = head_entry.pred_jump;
        end
`ifdef INS_QUEUE_BYPASS_EN
        if (empty && in_valid && rdy && !flush) begin
            out_valid     = TRUE;
            out_inst      = in_inst;
            out_pc        = in_pc;
            out_pred_jump = in_pred_jump;
        end
`endif
    end

    // Pointer and occupancy next state; flush overrides any same-cycle traffic.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (rdy && flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq) begin
                tail_d = tail_q + PTR_W'(1);
            end
            if (deq) begin
                head_d = head_q + PTR_W'(1);
            end
            case ({enq, deq})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is deliberately not reset; the count gates what is visible.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem_q[tail_q] <= '{inst: in_inst, pc: in_pc, pred_jump: in_pred_jump};
        end
    end

endmodule
